line_rasterizer: RTL and testbench

//   Receiving end of the coordinate interface driven by the animation calculator.

---
 rtl/line_rasterizer_if.sv | 25 ++
 rtl/line_rasterizer.sv | 118 +++++++++++
 tb/tb_line_rasterizer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_rasterizer_if.sv
// Coordinate/pixel bundle between the animation calculator,
// the line rasterizer and the framebuffer writer.
interface line_rasterizer_if;
  logic [9:0] x0;
  logic [9:0] x1;
  logic [8:0] y0;
  logic [8:0] y1;
  logic       set;
  logic       pix_ready;
  logic [9:0] x;
  logic [8:0] y;
  logic       pix_valid;
  logic       busy;
  logic       done;

  modport master (
    output x0, x1, y0, y1, set, pix_ready,
    input  x, y, pix_valid, busy, done
  );

  modport slave (
    input  x0, x1, y0, y1, set, pix_ready,
    output x, y, pix_valid, busy, done
  );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line stepper: latches endpoints on set and emits
// one visible pixel per accepted valid/ready handshake.
module line_rasterizer #(
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input logic            clk,
  input logic            reset,
  line_rasterizer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [9:0] ax0;
  logic [9:0] ax1;
  logic [8:0] ay0;
  logic [8:0] ay1;
  logic [9:0] cx;
  logic [8:0] cy;
  logic [9:0] dx;
  logic signed [10:0] dy;
  logic       sx;
  logic       sy;
  logic signed [12:0] err;

  logic       visible;
  logic       at_end;
  logic       step;
  logic [9:0] dx_l;
  logic [8:0] dya_l;
  logic signed [10:0] dy_l;
  logic signed [12:0] err_l;
  logic signed [12:0] e2;
  logic signed [12:0] dx_s;
  logic signed [12:0] dy_s;
  logic       step_x;
  logic       step_y;
  logic signed [12:0] err_n;

  always_comb begin
    visible = (cx < 10'(X_MAX)) && (cy < 9'(Y_MAX));
    at_end  = (cx == ax1) && (cy == ay1);
    step    = (state == DRAW) && (!visible || bus.pix_ready);
    dx_l    = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dya_l   = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    dy_l    = 11'sd0 - $signed({2'b00, dya_l});
    err_l   = $signed({3'b000, dx_l})
            + $signed({{2{dy_l[10]}}, dy_l});
    e2      = err <<< 1;
    dx_s    = $signed({3'b000, dx});
    dy_s    = $signed({{2{dy[10]}}, dy});
    step_x  = e2 >= dy_s;
    step_y  = e2 <= dx_s;
    // both axis updates see the pre-step error term
    err_n   = err
            + (step_x ? dy_s : 13'sd0)
            + (step_y ? dx_s : 13'sd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ax0   <= '0;
      ax1   <= '0;
      ay0   <= '0;
      ay1   <= '0;
      cx    <= '0;
      cy    <= '0;
      dx    <= '0;
      dy    <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      err   <= '0;
    end else if (bus.set) begin
      ax0   <= bus.x0;
      ax1   <= bus.x1;
      ay0   <= bus.y0;
      ay1   <= bus.y1;
      state <= LOAD;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          dx    <= dx_l;
          dy    <= dy_l;
          sx    <= ax1 >= ax0;
          sy    <= ay1 >= ay0;
          err   <= err_l;
          cx    <= ax0;
          cy    <= ay0;
          state <= DRAW;
        end
        DRAW: begin
          if (step) begin
            if (at_end) begin
              state <= DONE;
            end else begin
              err <= err_n;
              if (step_x) cx <= sx ? cx + 10'd1 : cx - 10'd1;
              if (step_y) cy <= sy ? cy + 9'd1 : cy - 9'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x         = cx;
  assign bus.y         = cy;
  assign bus.pix_valid = (state == DRAW) && visible;
  assign bus.busy      = (state == LOAD) || (state == DRAW);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: timing, Bresenham
// sequences, backpressure, restart, clipping and reset.
module tb_line_rasterizer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [9:0] qx[$];
  logic [8:0] qy[$];
  int ndone;
  int ninvis;
  int nstall;
  int unstable;
  int ncyc;
  int first_cyc;

  line_rasterizer_if bus ();

  line_rasterizer #(.X_MAX(640), .Y_MAX(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no end, need finish");
    $fatal(1);
  end

  task automatic do_set(input int ax0, input int ay0,
                        input int ax1, input int ay1);
    @(negedge clk);
    bus.set       = 1'b1;
    bus.pix_ready = 1'b0;
    bus.x0        = 10'(ax0);
    bus.y0        = 9'(ay0);
    bus.x1        = 10'(ax1);
    bus.y1        = 9'(ay1);
    @(negedge clk);
    bus.set = 1'b0;
    bus.x0  = 'x;
    bus.y0  = 'x;
    bus.x1  = 'x;
    bus.y1  = 'x;
  endtask

  task automatic collect(input int bound, input int stall_x,
                         input int stall_n, input int max_acc);
    bit         held;
    logic [9:0] hx;
    logic [8:0] hy;
    int         stalls;
    qx.delete();
    qy.delete();
    ndone     = 0;
    ninvis    = 0;
    unstable  = 0;
    ncyc      = 0;
    first_cyc = -1;
    held      = 0;
    hx        = '0;
    hy        = '0;
    stalls    = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      ncyc = c;
      if (held && (bus.pix_valid !== 1'b1
          || bus.x !== hx || bus.y !== hy))
        unstable++;
      held = 0;
      if (bus.done === 1'b1) begin
        if (bus.pix_valid !== 1'b0) unstable++;
        ndone++;
        break;
      end
      if (bus.pix_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        if (int'(bus.x) == stall_x && stalls < stall_n) begin
          bus.pix_ready = 1'b0;
          stalls++;
          held = 1;
          hx   = bus.x;
          hy   = bus.y;
        end else begin
          bus.pix_ready = 1'b1;
          qx.push_back(bus.x);
          qy.push_back(bus.y);
          if (qx.size() == max_acc) break;
        end
      end else begin
        bus.pix_ready = 1'b1;
        if (bus.busy === 1'b1) ninvis++;
      end
    end
    nstall        = stalls;
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0
        || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got v=%b b=%b d=%b need 0 0 0",
               bus.pix_valid, bus.busy, bus.done);
    end
    checks++;
    if (bus.x !== 10'd0 || bus.y !== 9'd0) begin
      failures++;
      $display("FAIL reset_xy: got (%0d,%0d) need (0,0)",
               bus.x, bus.y);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vertical();
    int bad;
    do_set(20, 20, 20, 460);
    checks++;
    if (bus.busy !== 1'b1 || bus.pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL vert_load: got b=%b v=%b need 1 0",
               bus.busy, bus.pix_valid);
    end
    collect(600, -1, 0, 0);
    checks++;
    if (first_cyc !== 1) begin
      failures++;
      $display("FAIL vert_first: got cycle %0d need 1", first_cyc);
    end
    checks++;
    if (qx.size() != 441) begin
      failures++;
      $display("FAIL vert_count: got %0d need 441", qx.size());
    end
    bad = 0;
    foreach (qx[i])
      if (qx[i] !== 10'd20 || int'(qy[i]) != 20 + i) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL vert_seq: got %0d bad pixels need 0", bad);
    end
    checks++;
    if (ndone != 1 || ncyc != 442) begin
      failures++;
      $display("FAIL vert_done: got done=%0d at %0d need 1 at 442",
               ndone, ncyc);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL vert_after: got b=%b d=%b need 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_shallow();
    int fx[5] = '{0, 1, 2, 3, 4};
    int fy[5] = '{0, 1, 1, 2, 2};
    int rx[5] = '{4, 3, 2, 1, 0};
    int ry[5] = '{2, 1, 1, 0, 0};
    do_set(0, 0, 4, 2);
    collect(50, -1, 0, 0);
    checks++;
    if (qx.size() != 5 || ndone != 1) begin
      failures++;
      $display("FAIL fwd_count: got n=%0d d=%0d need 5 1",
               qx.size(), ndone);
    end
    for (int i = 0; i < 5 && i < qx.size(); i++) begin
      checks++;
      if (int'(qx[i]) != fx[i] || int'(qy[i]) != fy[i]) begin
        failures++;
        $display("FAIL fwd_pix%0d: got (%0d,%0d) need (%0d,%0d)",
                 i, qx[i], qy[i], fx[i], fy[i]);
      end
    end
    do_set(4, 2, 0, 0);
    collect(50, -1, 0, 0);
    checks++;
    if (qx.size() != 5 || ndone != 1) begin
      failures++;
      $display("FAIL rev_count: got n=%0d d=%0d need 5 1",
               qx.size(), ndone);
    end
    for (int i = 0; i < 5 && i < qx.size(); i++) begin
      checks++;
      if (int'(qx[i]) != rx[i] || int'(qy[i]) != ry[i]) begin
        failures++;
        $display("FAIL rev_pix%0d: got (%0d,%0d) need (%0d,%0d)",
                 i, qx[i], qy[i], rx[i], ry[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_set(0, 0, 9, 0);
    collect(50, 4, 3, 0);
    checks++;
    if (nstall != 3 || unstable != 0) begin
      failures++;
      $display("FAIL bp_hold: got stalls=%0d unstable=%0d need 3 0",
               nstall, unstable);
    end
    bad = 0;
    foreach (qx[i])
      if (int'(qx[i]) != i || qy[i] !== 9'd0) bad++;
    checks++;
    if (qx.size() != 10 || bad != 0 || ndone != 1) begin
      failures++;
      $display("FAIL bp_seq: got n=%0d bad=%0d d=%0d need 10 0 1",
               qx.size(), bad, ndone);
    end
  endtask

  task automatic test_restart();
    int total;
    do_set(20, 20, 620, 460);
    collect(200, -1, 0, 50);
    total = ndone;
    checks++;
    if (qx.size() != 50) begin
      failures++;
      $display("FAIL rs_first: got %0d accepts need 50", qx.size());
    end
    do_set(5, 5, 5, 5);
    collect(50, -1, 0, 0);
    total += ndone;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) total++;
    end
    checks++;
    if (qx.size() != 1 || qx[0] !== 10'd5 || qy[0] !== 9'd5) begin
      failures++;
      $display("FAIL rs_pixel: got n=%0d (%0d,%0d) need 1 (5,5)",
               qx.size(), qx[0], qy[0]);
    end
    checks++;
    if (total != 1) begin
      failures++;
      $display("FAIL rs_done: got %0d pulses need 1", total);
    end
  endtask

  task automatic test_clip();
    do_set(630, 0, 650, 0);
    collect(100, -1, 0, 0);
    checks++;
    if (qx.size() != 10 || qx[0] !== 10'd630
        || qx[qx.size()-1] !== 10'd639) begin
      failures++;
      $display("FAIL clipx_vis: got n=%0d first=%0d last=%0d need 10 630 639",
               qx.size(), qx[0], qx[qx.size()-1]);
    end
    checks++;
    if (ninvis != 11 || ndone != 1) begin
      failures++;
      $display("FAIL clipx_inv: got inv=%0d d=%0d need 11 1",
               ninvis, ndone);
    end
    do_set(0, 470, 0, 500);
    collect(100, -1, 0, 0);
    checks++;
    if (qy.size() != 10 || qy[0] !== 9'd470
        || qy[qy.size()-1] !== 9'd479) begin
      failures++;
      $display("FAIL clipy_vis: got n=%0d first=%0d last=%0d need 10 470 479",
               qy.size(), qy[0], qy[qy.size()-1]);
    end
    checks++;
    if (ninvis != 21 || ndone != 1) begin
      failures++;
      $display("FAIL clipy_inv: got inv=%0d d=%0d need 21 1",
               ninvis, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int late;
    do_set(0, 0, 100, 0);
    collect(50, -1, 0, 10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0
        || bus.done !== 1'b0 || bus.x !== 10'd0
        || bus.y !== 9'd0) begin
      failures++;
      $display("FAIL rst_mid: got v=%b b=%b d=%b (%0d,%0d) need 0 0 0 (0,0)",
               bus.pix_valid, bus.busy, bus.done, bus.x, bus.y);
    end
    reset = 1'b0;
    late = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL rst_quiet: got %0d active cycles need 0", late);
    end
    do_set(1, 1, 3, 1);
    collect(50, -1, 0, 0);
    checks++;
    if (qx.size() != 3 || qx[0] !== 10'd1 || qx[2] !== 10'd3
        || qy[1] !== 9'd1 || ndone != 1) begin
      failures++;
      $display("FAIL rst_redraw: got n=%0d d=%0d need 3 pixels 1..3 and 1 done",
               qx.size(), ndone);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.set       = 1'b0;
    bus.pix_ready = 1'b1;
    bus.x0        = '0;
    bus.x1        = '0;
    bus.y0        = '0;
    bus.y1        = '0;
    test_reset();
    test_vertical();
    test_shallow();
    test_backpressure();
    test_restart();
    test_clip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
